// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity constants and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PAR_FN_W = 32;

  // Zero-extension by the caller does not change the XOR reduction.
  function automatic logic calc_parity(input logic [PAR_FN_W-1:0] data, input logic par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit index for the UART transmitter data phase.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  next_bit_c,
  output logic                  last_bit_c
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sreg, sreg_d;
  logic [IDX_W-1:0]      idx, idx_d;

  assign last_bit_c = (idx == IDX_W'(DATA_WIDTH - 1));
  // Bit the line will carry after this edge, so the FSM can register it.
  assign next_bit_c = sreg_d[0];

  always_comb begin
    sreg_d = sreg;
    idx_d  = idx;
    if (load) begin
      sreg_d = data;
      idx_d  = '0;
    end else if (shift) begin
      sreg_d = sreg >> 1;
      idx_d  = last_bit_c ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      idx  <= '0;
    end else begin
      sreg <= sreg_d;
      idx  <= idx_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop bit(s); registered outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  uart_state_e      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             par_bit, par_en_lat;
  logic             stop_idx, stop_idx_d;
  logic             tx_d, busy_d;
  logic             load, shift;
  logic             bit_end_c, last_stop_c;
  logic             next_bit_c, last_bit_c;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .shift      (shift),
    .data       (P_DATA),
    .next_bit_c (next_bit_c),
    .last_bit_c (last_bit_c)
  );

  assign bit_end_c   = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_stop_c = (STOP_BITS == 1) || stop_idx;

  // Next state and next line level; outputs are registered from state_d.
  always_comb begin
    state_d    = state;
    stop_idx_d = stop_idx;
    load       = 1'b0;
    shift      = 1'b0;
    cnt_d      = (state == IDLE || bit_end_c) ? '0 : cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (Data_valid) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START:  if (bit_end_c) state_d = DATA;
      DATA: begin
        if (bit_end_c) begin
          shift = 1'b1;
          if (last_bit_c) state_d = par_en_lat ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end_c) state_d = STOP;
      STOP: begin
        if (bit_end_c) begin
          if (last_stop_c) begin
            state_d    = IDLE;
            stop_idx_d = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        stop_idx_d = 1'b0;
        cnt_d      = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = next_bit_c;
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      stop_idx   <= 1'b0;
      par_bit    <= 1'b0;
      par_en_lat <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      stop_idx <= stop_idx_d;
      TX_OUT   <= tx_d;
      Busy     <= busy_d;
      if (load) begin
        par_bit    <= calc_parity(PAR_FN_W'(P_DATA), PAR_TYP);
        par_en_lat <= PAR_EN;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line levels queued per frame, checked every cycle.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] p_data = 8'h00, p_data2 = 8'h00;
  logic       dv = 1'b0, dv2 = 1'b0;
  logic       par_en = 1'b0, par_typ = 1'b0, par_en2 = 1'b0, par_typ2 = 1'b0;
  logic       tx, busy, tx2, busy2;

  int   checks = 0;
  int   errors = 0;
  logic sb[$];

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .P_DATA(p_data), .Data_valid(dv),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx), .Busy(busy)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .P_DATA(p_data2), .Data_valid(dv2),
    .PAR_EN(par_en2), .PAR_TYP(par_typ2), .TX_OUT(tx2), .Busy(busy2)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int stops);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(d[i]);
    if (pe) sb.push_back((^d) ^ pt);
    for (int i = 0; i < stops; i++) sb.push_back(1'b1);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    if (sel) begin
      p_data2 = d;
      dv2     = 1'b1;
      push_frame(d, 1'b0, 1'b0, 2);
    end else begin
      p_data  = d;
      par_en  = pe;
      par_typ = pt;
      dv      = 1'b1;
      push_frame(d, pe, pt, 1);
    end
  endtask

  // Pops the queued frame bit by bit, checking line and Busy every cycle, then one idle cycle.
  task automatic expect_frame(input string tag, input bit sel, input bit keep_dv, input int disturb);
    int   cpb;
    int   n;
    logic b;
    cpb = sel ? 2 : 4;
    n   = 0;
    while (sb.size() > 0) begin
      b = sb.pop_front();
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        check({tag, " tx"}, sel ? tx2 : tx, b);
        check({tag, " busy"}, sel ? busy2 : busy, 1'b1);
        if (n == 0) begin
          if (keep_dv) p_data = 8'hFF;
          else begin
            dv  = 1'b0;
            dv2 = 1'b0;
          end
        end
        if (disturb > 0 && n == disturb) begin
          dv      = 1'b1;
          p_data  = 8'hFF;
          par_en  = ~par_en;
          par_typ = ~par_typ;
        end else if (disturb > 0 && n == disturb + 1) begin
          dv = 1'b0;
        end
        n++;
      end
    end
    @(negedge clk);
    check({tag, " idle tx"}, sel ? tx2 : tx, 1'b1);
    check({tag, " idle busy"}, sel ? busy2 : busy, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst tx2", tx2, 1'b1);
    check("rst busy2", busy2, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain frame, no parity
    send(1'b0, 8'hA5, 1'b0, 1'b0);
    expect_frame("t1 A5", 1'b0, 1'b0, 0);

    // 2: parity even/odd
    send(1'b0, 8'hA5, 1'b1, 1'b0);
    expect_frame("t2 A5 even", 1'b0, 1'b0, 0);
    send(1'b0, 8'hA5, 1'b1, 1'b1);
    expect_frame("t2 A5 odd", 1'b0, 1'b0, 0);
    send(1'b0, 8'h07, 1'b1, 1'b0);
    expect_frame("t2 07 even", 1'b0, 1'b0, 0);

    // 3: back-to-back with Data_valid held high
    send(1'b0, 8'h00, 1'b0, 1'b0);
    expect_frame("t3 00", 1'b0, 1'b1, 0);
    push_frame(8'hFF, 1'b0, 1'b0, 1);
    expect_frame("t3 FF", 1'b0, 1'b0, 0);

    // 4: request and config changes mid-frame are ignored
    send(1'b0, 8'h3C, 1'b1, 1'b0);
    expect_frame("t4 3C", 1'b0, 1'b0, 10);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t4 no 2nd tx", tx, 1'b1);
      check("t4 no 2nd busy", busy, 1'b0);
    end

    // 5: asynchronous reset during data bit 3
    send(1'b0, 8'hF0, 1'b0, 1'b0);
    sb.delete();
    @(negedge clk);
    dv = 1'b0;
    repeat (17) @(negedge clk);
    check("t5 bit3 low", tx, 1'b0);
    check("t5 bit3 busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t5 async tx", tx, 1'b1);
    check("t5 async busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 post tx", tx, 1'b1);
    check("t5 post busy", busy, 1'b0);
    send(1'b0, 8'h81, 1'b0, 1'b0);
    expect_frame("t5 81", 1'b0, 1'b0, 0);

    // 6: two stop bits, 2 clocks per bit
    send(1'b1, 8'h55, 1'b0, 1'b0);
    expect_frame("t6 55", 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
